// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage, producer side of the IFU->IDU valid/ready pipe.
// Issues one imem request at a time from the architectural fetch PC, packs the
// returned word with its PC into an output register, and handles BRU redirects
// by discarding any stale in-flight fetch.
module ifu_fetch #(
  parameter int unsigned          CPU_WIDTH = 64,
  parameter int unsigned          INS_WIDTH = 32,
  parameter int unsigned          BUS_WIDTH = 64,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = 64'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  // redirect from the BRU
  input  logic                 i_bru_jmpen,
  input  logic [CPU_WIDTH-1:0] i_bru_jmppc,
  // imem request channel
  output logic                 o_imem_req_valid,
  input  logic                 i_imem_req_ready,
  output logic [CPU_WIDTH-1:0] o_imem_addr,
  // imem response channel
  input  logic                 i_imem_rsp_valid,
  output logic                 o_imem_rsp_ready,
  input  logic [BUS_WIDTH-1:0] i_imem_rdata,
  // to the decode stage
  output logic                 o_post_valid,
  input  logic                 i_post_ready,
  output logic [INS_WIDTH-1:0] o_ifu_ins,
  output logic [CPU_WIDTH-1:0] o_ifu_pc,
  // simulation aid: redirect target was not word aligned
  output logic                 s_ifu_misalign
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  logic [CPU_WIDTH-1:0]   r_pc;        // architectural fetch PC
  logic [CPU_WIDTH-1:0]   r_req_addr;  // address of the request being offered
  logic                   r_drop;      // the outstanding response is stale
  logic                   r_post_valid;
  logic [INS_WIDTH-1:0]   r_ins;
  logic [CPU_WIDTH-1:0]   r_ifu_pc;
  logic                   r_misalign;

  logic [CPU_WIDTH-1:0]   w_jmp_target;
  logic [INS_WIDTH-1:0]   w_rsp_word;

  // Redirect target forced to a 4-byte boundary; word picked by pc[2] from the 8-byte beat.
  assign w_jmp_target = {i_bru_jmppc[CPU_WIDTH-1:2], 2'b00};
  assign w_rsp_word   = r_pc[2] ? i_imem_rdata[INS_WIDTH +: INS_WIDTH]
                                : i_imem_rdata[0 +: INS_WIDTH];

  assign o_imem_req_valid = (r_state == S_REQ);
  assign o_imem_rsp_ready = (r_state == S_WAIT);
  assign o_imem_addr      = r_req_addr & ~CPU_WIDTH'(7);
  assign o_post_valid     = r_post_valid;
  assign o_ifu_ins        = r_ins;
  assign o_ifu_pc         = r_ifu_pc;
  assign s_ifu_misalign   = r_misalign;

  // Fetch FSM: REQ -> WAIT -> HOLD, with redirect handling in every state.
  // NOTE: all state here is sequential, so every assignment is non-blocking and
  // the async reset branch gives each register a defined value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_drop       <= 1'b0;
      r_post_valid <= 1'b0;
      r_ins        <= '0;
      r_ifu_pc     <= '0;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= i_bru_jmpen && (i_bru_jmppc[1:0] != 2'b00);
      if (i_bru_jmpen) begin
        r_pc <= w_jmp_target;
      end

      unique case (r_state)
        S_REQ: begin
          // The offered request must stay stable, so a redirect only marks
          // its eventual response as stale.
          if (i_bru_jmpen) begin
            r_drop <= 1'b1;
          end
          if (i_imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (i_imem_rsp_valid) begin
            if (i_bru_jmpen) begin
              // Response arrives with the redirect: discard and go straight to the target.
              r_req_addr <= w_jmp_target;
              r_drop     <= 1'b0;
              r_state    <= S_REQ;
            end else if (r_drop) begin
              // Stale response: discard and refetch from the redirected PC.
              r_req_addr <= r_pc;
              r_drop     <= 1'b0;
              r_state    <= S_REQ;
            end else begin
              r_ins        <= w_rsp_word;
              r_ifu_pc     <= r_pc;
              r_pc         <= r_pc + CPU_WIDTH'(4);
              r_post_valid <= 1'b1;
              r_state      <= S_HOLD;
            end
          end else if (i_bru_jmpen) begin
            r_drop <= 1'b1;
          end
        end

        S_HOLD: begin
          // A redirect here never cancels a handshake happening the same cycle;
          // squashing an already-issued instruction is done downstream.
          if (i_bru_jmpen) begin
            r_post_valid <= 1'b0;
            r_req_addr   <= w_jmp_target;
            r_state      <= S_REQ;
          end else if (i_post_ready) begin
            r_post_valid <= 1'b0;
            r_req_addr   <= r_pc;
            r_state      <= S_REQ;
          end
        end

        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  // Only one request may be outstanding, so a response is legal only in WAIT.
  a_rsp_only_in_wait : assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
      i_imem_rsp_valid |-> (r_state == S_WAIT)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: bench for ifu_fetch. A behavioural imem with configurable
// latency and a decode-side sink are stepped together once per cycle on the
// falling edge; expected PCs go into a scoreboard queue and are popped when
// the DUT hands an instruction off.
module tb_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_bru_jmpen;
  logic [63:0] i_bru_jmppc;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready;
  logic [63:0] o_imem_addr;
  logic        i_imem_rsp_valid;
  logic        o_imem_rsp_ready;
  logic [63:0] i_imem_rdata;
  logic        o_post_valid;
  logic        i_post_ready;
  logic [31:0] o_ifu_ins;
  logic [63:0] o_ifu_pc;
  logic        s_ifu_misalign;

  ifu_fetch #(
    .CPU_WIDTH (64),
    .INS_WIDTH (32),
    .BUS_WIDTH (64),
    .RESET_PC  (RESET_PC)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_bru_jmpen      (i_bru_jmpen),
    .i_bru_jmppc      (i_bru_jmppc),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_addr      (o_imem_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .o_imem_rsp_ready (o_imem_rsp_ready),
    .i_imem_rdata     (i_imem_rdata),
    .o_post_valid     (o_post_valid),
    .i_post_ready     (i_post_ready),
    .o_ifu_ins        (o_ifu_ins),
    .o_ifu_pc         (o_ifu_pc),
    .s_ifu_misalign   (s_ifu_misalign)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  // imem model state
  bit          pend;
  int          cnt;
  logic [63:0] pend_addr;
  int          lat;
  bit          req_ready_cfg;
  logic [63:0] req_log[$];

  // sink / scoreboard state
  bit          sink_ready;
  logic [63:0] exp_q[$];
  int          handoffs;

  typedef struct {
    int          lat;
    int          stall;
    logic [63:0] exp_pc;
  } vec_t;
  vec_t vecs[4];

  // Instruction word stored at a given byte address of the imem model.
  function automatic logic [31:0] ins_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timeout", name);
  endtask

  // One clock cycle: drive inputs from the current outputs, then advance to the next falling edge.
  task automatic tick();
    logic [63:0] e;
    i_imem_rsp_valid = 1'b0;
    if (pend) begin
      if (cnt <= 1) begin
        check("rsp_ready_when_rsp", 64'(o_imem_rsp_ready), 64'd1);
        i_imem_rsp_valid = 1'b1;
        i_imem_rdata     = {ins_of(pend_addr + 64'd4), ins_of(pend_addr)};
        pend             = 1'b0;
      end else begin
        cnt--;
      end
    end
    i_imem_req_ready = req_ready_cfg;
    if (o_imem_req_valid && req_ready_cfg) begin
      pend      = 1'b1;
      cnt       = lat;
      pend_addr = o_imem_addr;
      req_log.push_back(o_imem_addr);
    end
    i_post_ready = sink_ready;
    if (o_post_valid && sink_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_handoff: got pc 0x%0h expected no instruction", o_ifu_pc);
      end else begin
        e = exp_q.pop_front();
        check("handoff_pc", o_ifu_pc, e);
        check("handoff_ins", 64'(o_ifu_ins), 64'(ins_of(e)));
      end
      handoffs++;
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_bru_jmpen = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!o_post_valid && n < 50) begin
      tick();
      n++;
    end
    if (!o_post_valid) timeout(name);
  endtask

  task automatic wait_rsp_ready(input string name);
    int n = 0;
    while (!o_imem_rsp_ready && n < 50) begin
      tick();
      n++;
    end
    if (!o_imem_rsp_ready) timeout(name);
  endtask

  task automatic wait_handoffs(input string name, input int target);
    int n = 0;
    while (handoffs < target && n < 50) begin
      tick();
      n++;
    end
    if (handoffs < target) timeout(name);
  endtask

  task automatic redirect(input logic [63:0] target);
    i_bru_jmpen = 1'b1;
    i_bru_jmppc = target;
  endtask

  initial begin
    int h0;
    int n0;

    vecs[0] = '{lat: 1, stall: 0, exp_pc: 64'h8000_0000};
    vecs[1] = '{lat: 1, stall: 0, exp_pc: 64'h8000_0004};
    vecs[2] = '{lat: 2, stall: 5, exp_pc: 64'h8000_0008};
    vecs[3] = '{lat: 3, stall: 1, exp_pc: 64'h8000_000C};

    i_rst_n          = 1'b0;
    i_bru_jmpen      = 1'b0;
    i_bru_jmppc      = '0;
    i_imem_req_ready = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rdata     = '0;
    i_post_ready     = 1'b0;
    pend             = 1'b0;
    cnt              = 0;
    pend_addr        = '0;
    lat              = 1;
    req_ready_cfg    = 1'b1;
    sink_ready       = 1'b0;
    handoffs         = 0;

    // Reset state
    repeat (2) @(negedge i_clk);
    check("rst_post_valid", 64'(o_post_valid), 64'd0);
    check("rst_ins", 64'(o_ifu_ins), 64'd0);
    check("rst_pc", o_ifu_pc, 64'd0);
    check("rst_misalign", 64'(s_ifu_misalign), 64'd0);
    check("rst_req_valid", 64'(o_imem_req_valid), 64'd1);
    check("rst_req_addr", o_imem_addr, RESET_PC);
    check("rst_rsp_ready", 64'(o_imem_rsp_ready), 64'd0);
    i_rst_n = 1'b1;

    // First fetch latency: accept, 1-cycle response, then valid
    tick();
    check("t1_wait_rsp_ready", 64'(o_imem_rsp_ready), 64'd1);
    check("t1_wait_req_valid", 64'(o_imem_req_valid), 64'd0);
    tick();
    check("t1_latency_valid", 64'(o_post_valid), 64'd1);
    check("t1_pc", o_ifu_pc, RESET_PC);
    check("t1_ins_low_word", 64'(o_ifu_ins), 64'(ins_of(RESET_PC)));

    // Sequential fetch table with backpressure
    for (int k = 0; k < 4; k++) begin
      lat = vecs[k].lat;
      wait_valid("vec_valid");
      n0 = req_log.size();
      for (int s = 0; s < vecs[k].stall; s++) begin
        tick();
        check("stall_valid", 64'(o_post_valid), 64'd1);
        check("stall_pc", o_ifu_pc, vecs[k].exp_pc);
        check("stall_ins", 64'(o_ifu_ins), 64'(ins_of(vecs[k].exp_pc)));
        check("stall_no_req", 64'(req_log.size()), 64'(n0));
      end
      exp_q.push_back(vecs[k].exp_pc);
      sink_ready = 1'b1;
      h0 = handoffs;
      tick();
      sink_ready = 1'b0;
      check("vec_handoff", 64'(handoffs), 64'(h0 + 1));
    end

    // Redirect in WAIT, response 3 cycles after accept is dropped
    lat = 3;
    wait_rsp_ready("t3_wait");
    n0 = req_log.size();
    redirect(64'h8000_0100);
    tick();
    check("t3_aligned_no_misalign", 64'(s_ifu_misalign), 64'd0);
    check("t3_still_wait", 64'(o_imem_rsp_ready), 64'd1);
    lat = 1;
    exp_q.push_back(64'h8000_0100);
    sink_ready = 1'b1;
    wait_handoffs("t3_handoff", handoffs + 1);
    sink_ready = 1'b0;
    check("t3_next_req_addr", req_log[n0], 64'h8000_0100);

    // Redirect in HOLD on the same cycle as the post handshake
    wait_valid("t4_valid");
    exp_q.push_back(64'h8000_0104);
    sink_ready = 1'b1;
    redirect(64'h8000_0200);
    h0 = handoffs;
    tick();
    sink_ready = 1'b0;
    check("t4_single_handoff", 64'(handoffs), 64'(h0 + 1));
    check("t4_valid_cleared", 64'(o_post_valid), 64'd0);
    check("t4_req_valid", 64'(o_imem_req_valid), 64'd1);
    check("t4_req_addr", o_imem_addr, 64'h8000_0200);
    tick();
    check("t4_no_dup_valid", 64'(o_post_valid), 64'd0);
    exp_q.push_back(64'h8000_0200);
    sink_ready = 1'b1;
    wait_handoffs("t4_handoff", handoffs + 1);
    sink_ready = 1'b0;

    // Misaligned redirect in HOLD without a handshake
    wait_valid("t5_valid");
    redirect(64'h8000_0102);
    tick();
    check("t5_misalign_pulse", 64'(s_ifu_misalign), 64'd1);
    check("t5_valid_cleared", 64'(o_post_valid), 64'd0);
    check("t5_req_addr", o_imem_addr, 64'h8000_0100);
    tick();
    check("t5_misalign_end", 64'(s_ifu_misalign), 64'd0);
    exp_q.push_back(64'h8000_0100);
    sink_ready = 1'b1;
    wait_handoffs("t5_handoff", handoffs + 1);
    sink_ready = 1'b0;

    // Redirect in REQ while imem refuses the request: address must hold
    req_ready_cfg = 1'b0;
    check("tq_req_valid", 64'(o_imem_req_valid), 64'd1);
    check("tq_req_addr", o_imem_addr, 64'h8000_0100);
    redirect(64'h8000_0300);
    tick();
    check("tq_addr_stable1", o_imem_addr, 64'h8000_0100);
    tick();
    check("tq_addr_stable2", o_imem_addr, 64'h8000_0100);
    n0 = req_log.size();
    req_ready_cfg = 1'b1;
    exp_q.push_back(64'h8000_0300);
    sink_ready = 1'b1;
    wait_handoffs("tq_handoff", handoffs + 1);
    sink_ready = 1'b0;
    check("tq_stale_req", req_log[n0], 64'h8000_0100);
    check("tq_target_req", req_log[n0 + 1], 64'h8000_0300);

    // Redirect in WAIT on the same cycle as the response
    lat = 2;
    wait_rsp_ready("tw_wait");
    tick();
    redirect(64'h8000_0400);
    tick();
    check("tw_req_valid", 64'(o_imem_req_valid), 64'd1);
    check("tw_req_addr", o_imem_addr, 64'h8000_0400);
    check("tw_no_valid", 64'(o_post_valid), 64'd0);
    lat = 1;
    exp_q.push_back(64'h8000_0400);
    sink_ready = 1'b1;
    wait_handoffs("tw_handoff", handoffs + 1);
    sink_ready = 1'b0;

    // Asynchronous reset while in WAIT
    lat = 3;
    wait_rsp_ready("t6_wait");
    tick();
    i_rst_n = 1'b0;
    #1;
    check("t6_rst_post_valid", 64'(o_post_valid), 64'd0);
    check("t6_rst_ins", 64'(o_ifu_ins), 64'd0);
    check("t6_rst_pc", o_ifu_pc, 64'd0);
    check("t6_rst_rsp_ready", 64'(o_imem_rsp_ready), 64'd0);
    check("t6_rst_req_valid", 64'(o_imem_req_valid), 64'd1);
    check("t6_rst_req_addr", o_imem_addr, RESET_PC);
    pend             = 1'b0;
    i_imem_rsp_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    n0 = req_log.size();
    lat = 1;
    exp_q.push_back(RESET_PC);
    sink_ready = 1'b1;
    wait_handoffs("t6_handoff", handoffs + 1);
    sink_ready = 1'b0;
    check("t6_first_req", req_log[n0], RESET_PC);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
